// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit simplified MIPS multicycle datapath control.
// Holds the ALU op codes, instruction opcodes, control FSM state encoding and
// the ALU operand-B select encodings.
package mips_pkg;

  // ALU operation codes; R-type opcodes reuse these values directly.
  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluNor  = 4'b1100;
  localparam logic [3:0] AluNand = 4'b1101;

  // Non-R-type opcodes.
  localparam logic [3:0] OpAddi = 4'b0100;
  localparam logic [3:0] OpLw   = 4'b1000;
  localparam logic [3:0] OpSw   = 4'b1001;
  localparam logic [3:0] OpBeq  = 4'b1010;
  localparam logic [3:0] OpBne  = 4'b1011;

  // ALU operand-B selects.
  localparam logic [1:0] SrcBReg = 2'b00;
  localparam logic [1:0] SrcBOne = 2'b01;
  localparam logic [1:0] SrcBImm = 2'b10;

  typedef enum logic [3:0] {
    StReset,
    StFetch,
    StDecode,
    StExecR,
    StExecI,
    StMemAddr,
    StMemRead,
    StMemWrite,
    StWbMem,
    StWbAlu,
    StBranch
  } state_e;

endpackage

// File: rtl/mips_alu_op_decode.sv
// Combinational opcode decoder shared by the control FSM and the ALU control path.
// Ports:
//   opcode   - instruction opcode IR[15:12]
//   is_rtype - opcode is an R-type (opcode doubles as the ALU op)
//   is_legal - opcode is defined
//   alu_op   - ALU op implied by the opcode (ADD for ADDI/LW/SW and undefined, SUB for branches)
module mips_alu_op_decode
  import mips_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_rtype,
  output logic       is_legal,
  output logic [3:0] alu_op
);

  always_comb begin
    is_rtype = 1'b0;
    is_legal = 1'b1;
    alu_op   = AluAdd;
    unique case (opcode)
      AluAnd, AluOr, AluAdd, AluSub, AluSlt, AluNor, AluNand: begin
        is_rtype = 1'b1;
        alu_op   = opcode;
      end
      OpAddi, OpLw, OpSw: alu_op = AluAdd;
      OpBeq, OpBne:       alu_op = AluSub;
      default:            is_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the 16-bit simplified MIPS datapath.
// Sequences fetch, decode, execute, memory access, writeback and PC update, drives
// the ALU op and operand selects, and aborts memory waits after TIMEOUT cycles.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   opcode              - IR[15:12], valid from DECODE onward
//   zero                - ALU zero flag
//   mem_ready           - memory accepts/returns this cycle
//   alu_op, alu_src_a, alu_src_b - ALU control
//   iord, mem_read, mem_write    - memory port control
//   ir_write, pc_write, pc_src   - IR/PC update control
//   reg_write, reg_dst, mem_to_reg - register file writeback control
//   instr_done, illegal_op, bus_error - one-cycle status pulses
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_error
);

  state_e        state_q, state_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          rd_sel_q, rd_sel_d;  // 1 = rd (R-type), 0 = rt (ADDI)

  logic       dec_is_rtype;
  logic       dec_is_legal;
  logic [3:0] dec_alu_op;
  logic       wait_full;
  logic       in_wait_state;

  mips_alu_op_decode u_decode (
    .opcode   (opcode),
    .is_rtype (dec_is_rtype),
    .is_legal (dec_is_legal),
    .alu_op   (dec_alu_op)
  );

  assign wait_full     = (wait_q == TW'(TIMEOUT));
  assign in_wait_state = (state_q == StFetch) || (state_q == StMemRead) ||
                         (state_q == StMemWrite);

  // Counter only advances while lingering in a wait state; any exit or
  // re-entry (including timeout back to FETCH) starts it from zero.
  always_comb begin
    wait_d = '0;
    if (in_wait_state && !mem_ready && !wait_full) begin
      wait_d = wait_q + TW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_sel_d   = rd_sel_q;
    alu_op     = AluAnd;
    alu_src_a  = 1'b0;
    alu_src_b  = SrcBReg;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    bus_error  = 1'b0;

    // Outputs are forced low for the whole time rst is high, even before the
    // first clock edge has loaded StReset.
    if (!rst) begin
      unique case (state_q)
        StReset: state_d = StFetch;

        StFetch: begin
          mem_read  = 1'b1;
          alu_src_b = SrcBOne;
          alu_op    = AluAdd;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          if (mem_ready) begin
            state_d = StDecode;
          end else if (wait_full) begin
            bus_error = 1'b1;
            state_d   = StFetch;
          end
        end

        StDecode: begin
          // Branch target precomputed into ALUOut.
          alu_src_b = SrcBImm;
          alu_op    = AluAdd;
          if (!dec_is_legal) begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
          end else if (dec_is_rtype) begin
            state_d = StExecR;
          end else if (opcode == OpAddi) begin
            state_d = StExecI;
          end else if ((opcode == OpLw) || (opcode == OpSw)) begin
            state_d = StMemAddr;
          end else begin
            state_d = StBranch;
          end
        end

        StExecR: begin
          alu_src_a = 1'b1;
          alu_src_b = SrcBReg;
          alu_op    = dec_alu_op;
          rd_sel_d  = 1'b1;
          state_d   = StWbAlu;
        end

        StExecI: begin
          alu_src_a = 1'b1;
          alu_src_b = SrcBImm;
          alu_op    = AluAdd;
          rd_sel_d  = 1'b0;
          state_d   = StWbAlu;
        end

        StWbAlu: begin
          reg_write  = 1'b1;
          reg_dst    = rd_sel_q;
          instr_done = 1'b1;
          state_d    = StFetch;
        end

        StMemAddr: begin
          alu_src_a = 1'b1;
          alu_src_b = SrcBImm;
          alu_op    = AluAdd;
          state_d   = (opcode == OpSw) ? StMemWrite : StMemRead;
        end

        StMemRead: begin
          iord     = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) begin
            state_d = StWbMem;
          end else if (wait_full) begin
            bus_error = 1'b1;
            state_d   = StFetch;
          end
        end

        StMemWrite: begin
          iord      = 1'b1;
          mem_write = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = StFetch;
          end else if (wait_full) begin
            bus_error = 1'b1;
            state_d   = StFetch;
          end
        end

        StWbMem: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end

        StBranch: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SrcBReg;
          alu_op     = AluSub;
          pc_src     = 1'b1;
          pc_write   = (opcode == OpBne) ? ~zero : zero;
          instr_done = 1'b1;
          state_d    = StFetch;
        end

        default: state_d = StReset;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StReset;
      wait_q   <= '0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      rd_sel_q <= rd_sel_d;
    end
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle control FSM for the 16-bit simplified MIPS datapath.
- It is the initiator of the ALU interface: each cycle it drives the ALU op code and operand selects, and it consumes the ALU zero flag for branches.
- It also sequences instruction fetch, memory handshakes, register writeback and PC update.
- Sits between the instruction register opcode field and the datapath muxes, ALU, register file and memory port.

Parameters:
- TIMEOUT, 15: maximum cycles a memory state waits for mem_ready before aborting.
- TW, 4: width of the wait counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  4  IR[15:12]; valid from DECODE onward.
- zero  in  1  ALU zero flag (result == 0), combinational from the ALU.
- mem_ready  in  1  memory accepts/returns this cycle.
- alu_op  out  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 NAND.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = register B, 01 = constant 1, 10 = sign-extended IR[7:0], 11 unused.
- iord  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load the IR.
- pc_write  out  1  load the PC.
- pc_src  out  1  0 = ALU result, 1 = ALUOut.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  0 = rt IR[9:8], 1 = rd IR[7:6].
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal_op  out  1  one-cycle pulse in DECODE on an undefined opcode.
- bus_error  out  1  one-cycle pulse when a memory wait times out.

Behaviour:
- Opcodes:
  - R-type, where opcode equals the ALU op: 0000, 0001, 0010, 0110, 0111, 1100, 1101.
  - ADDI 0100, LW 1000, SW 1001, BEQ 1010, BNE 1011.
  - All others are illegal.
- States: RESET, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_READ, MEM_WRITE, WB_MEM, WB_ALU, BRANCH.
- Reset: while rst is high, the state is RESET and every output is 0, including alu_op = 0000. The next cycle is FETCH. rst asserted mid-instruction aborts it with no further writes.
- Outputs are Moore (decoded from state). The only exceptions are pc_write/ir_write in FETCH and pc_write in BRANCH, which are qualified combinationally as noted below. Every unlisted output is 0 in every state.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=0.
  - ir_write = pc_write = mem_ready.
  - Go to DECODE when mem_ready is high; otherwise stay.
- DECODE:
  - alu_src_a=0, alu_src_b=10, alu_op=ADD; this precomputes the branch target into ALUOut.
  - Next state: R-type → EXEC_R; ADDI → EXEC_I; LW/SW → MEM_ADDR; BEQ/BNE → BRANCH.
  - Illegal opcode: illegal_op=1, instr_done=1, go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=opcode; go to WB_ALU with reg_dst=1.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=ADD; go to WB_ALU with reg_dst=0. The destination select is held in a flag register.
- WB_ALU: reg_write=1, mem_to_reg=0, reg_dst per the flag; instr_done=1; go to FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD; LW → MEM_READ, SW → MEM_WRITE.
- MEM_READ: iord=1, mem_read=1; go to WB_MEM on mem_ready.
- MEM_WRITE: iord=1, mem_write=1; on mem_ready, instr_done=1 and go to FETCH.
- WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; go to FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=1.
  - pc_write = zero for BEQ, ~zero for BNE.
  - instr_done=1; go to FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MEM_READ or MEM_WRITE, and increments each cycle that mem_ready is low.
  - If it reaches TIMEOUT with mem_ready still low: bus_error=1, all writes suppressed, go to FETCH (fetch is retried at the same PC).
  - mem_ready in the same cycle as the timeout takes priority (normal completion).
- Latency with mem_ready tied high:
  - R-type/ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/BNE: 3 cycles.
  - Illegal: 2 cycles.

Decomposition:
- mips_pkg holds:
  - the ALU op constants (AND, OR, ADD, SUB, SLT, NOR, NAND);
  - the opcode constants (ADDI, LW, SW, BEQ, BNE);
  - the state encoding;
  - the alu_src_b encodings.
- Sub-module mips_alu_op_decode is combinational: opcode → {is_rtype, is_legal, alu_op}. It is shared with the ALU control path.

Test Plan:
- rst held 3 cycles, then released with mem_ready=1 → all outputs 0 during reset; FETCH on the cycle after release with mem_read=1, ir_write=1, pc_write=1, alu_op=0010.
- opcode=0110 (SUB), mem_ready=1 → sequence FETCH, DECODE, EXEC_R (alu_op=0110, alu_src_b=00), WB_ALU (reg_write=1, reg_dst=1, instr_done=1); 4 cycles total.
- opcode=1000 (LW), mem_ready low for 3 cycles in MEM_READ → stays in MEM_READ with mem_read=1 and iord=1; WB_MEM follows with mem_to_reg=1; 8 cycles total.
- opcode=1010 (BEQ): with zero=1 → pc_write=1, pc_src=1 in BRANCH. With zero=0 → pc_write=0. BNE (1011) gives the inverse.
- mem_ready held 0 in FETCH → bus_error pulses once after 15 wait cycles, ir_write/pc_write stay 0, FETCH is re-entered. opcode=1111 → illegal_op=1 and instr_done=1 in DECODE, then FETCH.
